// File: rtl/cond_pkg.sv
//------------------------------------------------------------------------------
// cond_pkg : condition codes, flag bit positions and reset flag default
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] RESET_FLAGS_DEFAULT = 4'b0000;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
//------------------------------------------------------------------------------
// cond_eval : combinational ARM condition-code check against {N,Z,C,V}
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  // 4'b1111 falls into the default and passes like AL
  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      default: pass = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/apsr_cond_unit.sv
//------------------------------------------------------------------------------
// apsr_cond_unit : NZCV flag register, registered condition check, IT sequencer
// Optional IT sequencer compiled in with macro COND_IT_BLOCK_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apsr_cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = RESET_FLAGS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic [3:0] flags_in,
  output logic [3:0] flags,
  output logic       carry_out,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_pass_valid,
  output logic       cond_pass,
  input  logic       it_load,
  input  logic [3:0] it_firstcond,
  input  logic [3:0] it_mask,
  input  logic       instr_retire,
  output logic       it_active,
  output logic [3:0] it_cond
);

  logic [3:0] flags_q;
  logic       pass_q;
  logic       pass_valid_q;
  logic       w_pass;

  // Evaluated against the pre-write flags so a same-cycle flag_we is not seen
  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags_q),
    .pass  (w_pass)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q      <= RESET_FLAGS;
      pass_q       <= 1'b0;
      pass_valid_q <= 1'b0;
    end else begin
      if (flag_we) begin
        flags_q <= flags_in;
      end
      pass_valid_q <= cond_valid;
      if (cond_valid) begin
        pass_q <= w_pass;
      end
    end
  end

  assign flags           = flags_q;
  assign carry_out       = flags_q[FLAG_C];
  assign cond_pass_valid = pass_valid_q;
  assign cond_pass       = pass_q;

`ifdef COND_IT_BLOCK_EN
  logic [7:0] itstate_q;
  logic [7:0] itstate_d;

  // Shifting [4:0] moves the next then/else bit into the condition LSB
  always_comb begin
    itstate_d = itstate_q;
    if (it_load && (it_mask != 4'b0000)) begin
      itstate_d = {it_firstcond, it_mask};
    end else if (instr_retire && (itstate_q[3:0] != 4'b0000)) begin
      if (itstate_q[2:0] == 3'b000) begin
        itstate_d = 8'h00;
      end else begin
        itstate_d[4:0] = {itstate_q[3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      itstate_q <= 8'h00;
    end else begin
      itstate_q <= itstate_d;
    end
  end

  assign it_active = (itstate_q[3:0] != 4'b0000);
  assign it_cond   = itstate_q[7:4];
`else
  logic w_unused_it;

  assign w_unused_it = ^{it_load, it_firstcond, it_mask, instr_retire};
  assign it_active   = 1'b0;
  assign it_cond     = COND_AL;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apsr_cond_unit.sv
//------------------------------------------------------------------------------
// tb_apsr_cond_unit : scoreboard bench for apsr_cond_unit (either IT build)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_apsr_cond_unit;

  localparam logic [3:0] RST_FLAGS = 4'b0000;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [3:0] flags_in;
  logic [3:0] flags;
  logic       carry_out;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_pass_valid;
  logic       cond_pass;
  logic       it_load;
  logic [3:0] it_firstcond;
  logic [3:0] it_mask;
  logic       instr_retire;
  logic       it_active;
  logic [3:0] it_cond;

  int n_checks = 0;
  int n_errors = 0;

  logic       sb_q[$];
  logic [3:0] m_flags;
  int         m_len;
  int         m_idx;
  logic [3:0] m_conds[4];

  apsr_cond_unit #(.RESET_FLAGS(RST_FLAGS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flag_we         (flag_we),
    .flags_in        (flags_in),
    .flags           (flags),
    .carry_out       (carry_out),
    .cond_valid      (cond_valid),
    .cond            (cond),
    .cond_pass_valid (cond_pass_valid),
    .cond_pass       (cond_pass),
    .it_load         (it_load),
    .it_firstcond    (it_firstcond),
    .it_mask         (it_mask),
    .instr_retire    (instr_retire),
    .it_active       (it_active),
    .it_cond         (it_cond)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conditions come in complementary pairs; odd codes invert the even base
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'b111) return 1'b1;
    return c[0] ? ~base : base;
  endfunction

  function automatic logic exp_active();
`ifdef COND_IT_BLOCK_EN
    return (m_idx < m_len);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_itcond();
`ifdef COND_IT_BLOCK_EN
    return (m_idx < m_len) ? m_conds[m_idx] : 4'h0;
`else
    return 4'hE;
`endif
  endfunction

  task automatic cyc(input logic r, input logic we, input logic [3:0] fin,
                     input logic cv, input logic [3:0] c,
                     input logic itl, input logic [3:0] fc, input logic [3:0] mk,
                     input logic ret);
    rst_n = r; flag_we = we; flags_in = fin; cond_valid = cv; cond = c;
    it_load = itl; it_firstcond = fc; it_mask = mk; instr_retire = ret;
    if (r && cv) sb_q.push_back(ref_cond(m_flags, c));
    @(posedge clk);
    #1;
    if (!r) begin
      m_flags = RST_FLAGS;
      m_len = 0; m_idx = 0;
    end else begin
      if (we) m_flags = fin;
      if (itl && mk != 4'b0000) begin
        m_len = mk[0] ? 4 : mk[1] ? 3 : mk[2] ? 2 : 1;
        m_idx = 0;
        m_conds[0] = fc;
        for (int i = 1; i < 4; i++) m_conds[i] = {fc[3:1], mk[4-i]};
      end else if (ret && m_idx < m_len) begin
        m_idx++;
      end
    end
    chk("flags", 8'(flags), 8'(m_flags));
    chk("carry_out", 8'(carry_out), 8'(m_flags[1]));
    chk("it_active", 8'(it_active), 8'(exp_active()));
    chk("it_cond", 8'(it_cond), 8'(exp_itcond()));
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic req(input logic [3:0] c);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, c, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic wflags(input logic [3:0] f);
    cyc(1'b1, 1'b1, f, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic itload(input logic [3:0] fc, input logic [3:0] mk, input logic ret);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, fc, mk, ret);
  endtask

  task automatic retire();
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (cond_pass_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 8'(cond_pass_valid), 8'h00);
      end else begin
        chk("cond_pass", 8'(cond_pass), 8'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    m_flags = RST_FLAGS; m_len = 0; m_idx = 0;
    for (int i = 0; i < 4; i++) m_conds[i] = 4'h0;

    cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("rst_valid", 8'(cond_pass_valid), 8'h00);
    chk("rst_pass", 8'(cond_pass), 8'h00);

    // 0x80000000 + 0x7FFFFFFF: N only
    wflags(4'b1000);
    req(4'h4); req(4'h5); req(4'hB); req(4'hA);
    idle(); idle();

    // SUBS 0x80000000 - 0x7FFFFFFF: C and V
    wflags(4'b0011);
    req(4'h8); req(4'h6); req(4'hA); req(4'hD);
    idle();
    chk("hold_valid", 8'(cond_pass_valid), 8'h00);
    chk("hold_pass", 8'(cond_pass), 8'h01);
    req(4'hE); req(4'hF);
    idle();

    // Same-cycle write and request sees the old flags
    wflags(4'b0000);
    cyc(1'b1, 1'b1, 4'b0100, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    req(4'h0);
    idle();

    // Two-instruction block EQ then NE
    itload(4'h0, 4'b1100, 1'b0);
    retire();
    retire();
    itload(4'h3, 4'b0000, 1'b0);
    retire();

    // Four-instruction block, then a fifth retire with nothing active
    itload(4'hA, 4'b0001, 1'b0);
    retire(); retire(); retire(); retire();
    retire();

    // Load wins over a simultaneous retire
    itload(4'h1, 4'b1000, 1'b0);
    itload(4'h6, 4'b0110, 1'b1);
    retire();

    // Reset mid-block with a request pending in the same cycle
    wflags(4'b1111);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b0101, 1'b1, 4'h0, 1'b1, 4'h2, 4'b0001, 1'b1);
    chk("mid_rst_valid", 8'(cond_pass_valid), 8'h00);
    chk("mid_rst_pass", 8'(cond_pass), 8'h00);

    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
          4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    idle(); idle();
    chk("sb_empty", 8'(sb_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
